// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped down-counting timer with prescaler and irq.
// Optional capture input and CAPTURE register under REFLET_TIMER_CAPTURE_EN.
module reflet_timer #(
  parameter int unsigned         wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq,
  input  logic                capture_in
);

  localparam int unsigned BYTES = wordsize / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam logic [wordsize-1:0] SPAN  = wordsize'(8 * BYTES);
  localparam logic [wordsize-1:0] ALIGN = wordsize'(BYTES - 1);
  localparam logic [wordsize-1:0] ONE   = wordsize'(1);

  logic [wordsize-1:0] off;
  logic [2:0]          idx;
  logic                sel;

  // offset wraps below base_addr, so one unsigned compare covers both bounds
  assign off = addr - base_addr;
  assign sel = (off < SPAN) && ((off & ALIGN) == '0);
  assign idx = 3'(off >> SHIFT);

  logic                run;
  logic                auto_reload;
  logic                irq_en;
  logic                expired;
  logic [wordsize-1:0] period;
  logic [wordsize-1:0] count;
  logic [wordsize-1:0] prescale;
  logic [wordsize-1:0] pcnt;
  logic [wordsize-1:0] cap_val;
  logic                cap_flag;

  logic wr;
  logic wr_ctrl;
  logic wr_period;
  logic wr_count;
  logic wr_status;
  logic wr_pre;

  assign wr        = enable && write_en && sel;
  assign wr_ctrl   = wr && (idx == 3'd0);
  assign wr_period = wr && (idx == 3'd1);
  assign wr_count  = wr && (idx == 3'd2);
  assign wr_status = wr && (idx == 3'd3);
  assign wr_pre    = wr && (idx == 3'd4);

  logic tick;
  logic expire;

  assign tick   = run && (pcnt == prescale);
  assign expire = tick && (count == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      run         <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      expired     <= 1'b0;
      period      <= '0;
      count       <= '0;
      prescale    <= '0;
      pcnt        <= '0;
    end else if (enable) begin
      if (wr_ctrl) begin
        run         <= data_in[0];
        auto_reload <= data_in[1];
        irq_en      <= data_in[2];
      end else if (expire && !auto_reload) begin
        run <= 1'b0;
      end

      if (wr_period)
        period <= data_in;

      if (wr_count)
        count <= data_in;
      else if (tick) begin
        if (count != '0)
          count <= count - ONE;
        else if (auto_reload)
          count <= period;
      end

      if (expire)
        expired <= 1'b1;
      else if (wr_status && data_in[0])
        expired <= 1'b0;

      if (wr_pre)
        prescale <= data_in;

      // stopping through CTRL clears the prescaler right away
      if ((wr_ctrl && !data_in[0]) || !run || tick)
        pcnt <= '0;
      else
        pcnt <= pcnt + ONE;
    end
  end

`ifdef REFLET_TIMER_CAPTURE_EN
  logic [2:0] sync;
  logic       cap_edge;

  assign cap_edge = sync[1] && !sync[2];

  always_ff @(posedge clk) begin
    if (!reset)
      sync <= 3'b000;
    else
      sync <= {sync[1:0], capture_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_val  <= '0;
      cap_flag <= 1'b0;
    end else if (enable) begin
      if (cap_edge)
        cap_val <= count;
      if (cap_edge)
        cap_flag <= 1'b1;
      else if (wr_status && data_in[1])
        cap_flag <= 1'b0;
    end
  end
`else
  logic unused_capture;

  assign unused_capture = capture_in;
  assign cap_val        = '0;
  assign cap_flag       = 1'b0;
`endif

  logic [wordsize-1:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd0:    rdata[2:0] = {irq_en, auto_reload, run};
      3'd1:    rdata = period;
      3'd2:    rdata = count;
      3'd3:    rdata[1:0] = {cap_flag, expired};
      3'd4:    rdata = prescale;
      3'd5:    rdata = cap_val;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      data_out <= '0;
    else if (enable)
      data_out <= (sel && !write_en) ? rdata : '0;
  end

  assign irq = expired && irq_en;

endmodule

// File: tb/tb_reflet_timer.sv
// tb_reflet_timer: directed and randomized checks of reflet_timer
// against an arithmetic model of expiry time and count value.
module tb_reflet_timer;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam int R_CTRL   = 0;
  localparam int R_PERIOD = 1;
  localparam int R_COUNT  = 2;
  localparam int R_STATUS = 3;
  localparam int R_PRE    = 4;
  localparam int R_CAP    = 5;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        write_en;
  logic [15:0] data_out;
  logic        irq;
  logic        capture_in;

  int tests = 0;
  int fails = 0;

  reflet_timer #(
    .wordsize (16),
    .base_addr(BASE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .addr      (addr),
    .data_in   (data_in),
    .write_en  (write_en),
    .data_out  (data_out),
    .irq       (irq),
    .capture_in(capture_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [15:0] v);
    @(negedge clk);
    addr     = BASE + 16'(2 * idx);
    data_in  = v;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    addr     = 16'h0000;
    data_in  = 16'h0000;
  endtask

  task automatic rd_raw(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk);
    addr     = a;
    write_en = 1'b0;
    @(posedge clk);
    #1;
    v    = data_out;
    addr = 16'h0000;
  endtask

  task automatic rd(input int idx, output logic [15:0] v);
    rd_raw(BASE + 16'(2 * idx), v);
  endtask

  // c = number of edges after the call until irq is seen high
  task automatic wait_irq(input int limit, output int c);
    c = 0;
    while (!irq && c <= limit) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  // COUNT after k prescaled edges from a start with empty prescaler,
  // auto-reload on
  function automatic int cnt_model(int c0, int per, int pre, int k);
    int n;
    n = k / (pre + 1);
    if (n <= c0)
      return c0 - n;
    n = n - (c0 + 1);
    return per - (n % (per + 1));
  endfunction

  initial begin
    logic [15:0] v;
    int          c;
    int          per;
    int          pre;
    int          c0;
    int          k;

    reset      = 1'b0;
    enable     = 1'b1;
    addr       = 16'h0000;
    data_in    = 16'h0000;
    write_en   = 1'b0;
    capture_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irq", irq, 0);
    check("rst_dout", data_out, 0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      check($sformatf("rst_reg%0d", i), v, 0);
    end

    // register access and decode
    wr(R_PERIOD, 16'h0123);
    wr(R_PRE, 16'h0002);
    rd(R_PERIOD, v);
    check("rw_period", v, 16'h0123);
    rd(R_PRE, v);
    check("rw_prescale", v, 16'h0002);
    rd_raw(16'h1234, v);
    check("unselected", v, 0);
    rd_raw(BASE + 16'd3, v);
    check("misaligned", v, 0);
    rd_raw(BASE + 16'd16, v);
    check("past_end", v, 0);
    wr(6, 16'hFFFF);
    rd(6, v);
    check("reg6", v, 0);
    wr(R_CTRL, 16'hFFF8);
    rd(R_CTRL, v);
    check("ctrl_mask", v, 0);

    // auto-reload
    wr(R_STATUS, 16'h0001);
    wr(R_PERIOD, 16'd3);
    wr(R_PRE, 16'd1);
    wr(R_COUNT, 16'd3);
    wr(R_CTRL, 16'h0007);
    wait_irq(40, c);
    check("ar_first", c, 8);
    wr(R_STATUS, 16'h0001);
    check("ar_clear", irq, 0);
    repeat (6) @(posedge clk);
    #1;
    check("ar_before2", irq, 0);
    @(posedge clk);
    #1;
    check("ar_second", irq, 1);
    wr(R_CTRL, 16'h0000);
    wr(R_STATUS, 16'h0001);

    // one-shot
    wr(R_PRE, 16'd0);
    wr(R_COUNT, 16'd2);
    wr(R_CTRL, 16'h0005);
    wait_irq(20, c);
    check("os_expiry", c, 3);
    repeat (20) @(posedge clk);
    rd(R_CTRL, v);
    check("os_ctrl", v, 16'h0004);
    rd(R_COUNT, v);
    check("os_count", v, 0);
    check("os_irq_held", irq, 1);
    wr(R_STATUS, 16'h0001);

    // clear in the expiry cycle
    wr(R_COUNT, 16'd2);
    wr(R_CTRL, 16'h0005);
    repeat (2) @(posedge clk);
    wr(R_STATUS, 16'h0001);
    rd(R_STATUS, v);
    check("col_set_wins", v, 16'h0001);
    wr(R_STATUS, 16'h0001);
    rd(R_STATUS, v);
    check("status_clear", v, 0);

    // COUNT write on a tick
    wr(R_COUNT, 16'd50);
    wr(R_CTRL, 16'h0003);
    repeat (3) @(posedge clk);
    wr(R_COUNT, 16'd9);
    rd(R_COUNT, v);
    check("col_count_wr", v, 16'd9);
    wr(R_CTRL, 16'h0000);

    // freeze
    wr(R_STATUS, 16'h0001);
    wr(R_PERIOD, 16'd3);
    wr(R_PRE, 16'd3);
    wr(R_COUNT, 16'd20);
    wr(R_CTRL, 16'h0003);
    repeat (4) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b1;
    rd(R_COUNT, v);
    check("frz_count", v, cnt_model(20, 3, 3, 4));
    repeat (3) @(posedge clk);
    rd(R_COUNT, v);
    check("frz_resume", v, cnt_model(20, 3, 3, 8));
    wr(R_CTRL, 16'h0000);

    // reset mid-count with irq pending and enable low
    wr(R_PRE, 16'd0);
    wr(R_COUNT, 16'd0);
    wr(R_CTRL, 16'h0005);
    @(posedge clk);
    #1;
    check("pre_rst_irq", irq, 1);
    wr(R_PRE, 16'hFFFF);
    wr(R_COUNT, 16'd5);
    wr(R_CTRL, 16'h0007);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_irq", irq, 0);
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      check($sformatf("midrst_reg%0d", i), v, 0);
    end

    // capture
    wr(R_COUNT, 16'h0040);
    @(negedge clk);
    capture_in = 1'b1;
    repeat (3) @(negedge clk);
    capture_in = 1'b0;
    repeat (6) @(posedge clk);
    rd(R_CAP, v);
`ifdef REFLET_TIMER_CAPTURE_EN
    check("cap_value", v, 16'h0040);
    rd(R_STATUS, v);
    check("cap_flag", v, 16'h0002);
    wr(R_CAP, 16'h1111);
    rd(R_CAP, v);
    check("cap_ro", v, 16'h0040);
    wr(R_STATUS, 16'h0002);
`else
    check("cap_absent", v, 0);
    rd(R_STATUS, v);
    check("cap_flag_absent", v, 0);
`endif

    // randomized expiry time and count trajectory
    for (int t = 0; t < 8; t++) begin
      per = int'($urandom_range(0, 4));
      pre = int'($urandom_range(0, 3));
      c0  = int'($urandom_range(0, 5));
      wr(R_CTRL, 16'h0000);
      wr(R_STATUS, 16'h0001);
      wr(R_PERIOD, 16'(per));
      wr(R_PRE, 16'(pre));
      wr(R_COUNT, 16'(c0));
      wr(R_CTRL, 16'h0007);
      wait_irq((c0 + 1) * (pre + 1) + 10, c);
      check($sformatf("rnd_expiry%0d", t), c, (c0 + 1) * (pre + 1));
      wr(R_CTRL, 16'h0000);
      wr(R_STATUS, 16'h0001);
      wr(R_COUNT, 16'(c0));
      wr(R_CTRL, 16'h0003);
      k = int'($urandom_range(0, 40));
      repeat (k) @(posedge clk);
      rd(R_COUNT, v);
      check($sformatf("rnd_count%0d", t), v, cnt_model(c0, per, pre, k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reflet_timer.md
Name: reflet_timer

Overview:
Memory-mapped down-counting timer on the CPU system bus. The CPU reaches it through its addr/data_out/write_en/data_in connections. The interrupt output drives one bit of the CPU interrupt_request vector. Read data is zero when the block is not addressed, so several peripherals' read buses can be OR-combined into the CPU data_in.

Parameters:
wordsize, 16, bus and register width (8, 16 or 32).
base_addr, 16'hFF00, byte address of register 0; must be aligned to 8*(wordsize/8).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low
enable  input  1  global enable; when low all state is frozen and bus writes are ignored
addr  input  wordsize  byte address from the CPU
data_in  input  wordsize  write data (CPU data_out)
write_en  input  1  bus write strobe
data_out  output  wordsize  registered read data; 0 when not addressed
irq  output  1  interrupt request (level)
capture_in  input  1  capture trigger; used only with the optional feature

Behaviour:
- Address decode:
  - Selected when addr is in [base_addr, base_addr+8*(wordsize/8)).
  - Word index = (addr-base_addr)/(wordsize/8).
  - Misaligned addresses are not selected.
- Registers, with reset values:
  - 0 CTRL: bit0 run, bit1 auto_reload, bit2 irq_en; other bits read 0. Reset 0.
  - 1 PERIOD: reload value. Reset 0.
  - 2 COUNT: current count; a write loads it. Reset 0.
  - 3 STATUS: bit0 expired. Writing 1 to bit0 clears it; writing 0 has no effect. Reset 0.
  - 4 PRESCALE: divider value. Reset 0.
  - 5 CAPTURE: see Optional Feature.
  - 6-7: read 0, writes ignored.
- Writes take effect at the clk edge where write_en=1, enable=1 and the address is selected.
- Reads:
  - data_out is registered and valid one cycle after addr is presented.
  - data_out <= 0 when not selected or when write_en=1.
  - Reset value of data_out is 0.
- Internal prescale counter pcnt (wordsize bits):
  - While run=1 and enable=1, pcnt increments each cycle.
  - When pcnt==PRESCALE: pcnt<=0 and a tick is generated.
  - When run=0: pcnt is held at 0.
- On tick:
  - If COUNT!=0: COUNT<=COUNT-1.
  - If COUNT==0: expired<=1 (expiry). Then, if auto_reload=1: COUNT<=PERIOD; else run<=0 and COUNT stays 0 (one-shot).
- Expiry period with auto-reload: (PERIOD+1)*(PRESCALE+1) cycles.
- irq = expired & irq_en, driven combinationally from registers. irq=0 at reset.
- Simultaneous events:
  - Expiry and a STATUS clear in the same cycle: set wins, expired stays 1.
  - COUNT write and a tick in the same cycle: the write wins; pcnt still wraps.
  - CTRL write and a one-shot expiry in the same cycle: the CTRL write value wins.
  - A CTRL write with run=0 forces pcnt to 0 on the next cycle.
- Wrap: COUNT never underflows. Its value 0 is the expiry point.
- Reset mid-count: all registers, pcnt, irq and data_out return to 0 on the next edge, regardless of enable.

Optional Feature:
Macro REFLET_TIMER_CAPTURE_EN.
- Defined:
  - capture_in is synchronised through two flops.
  - A rising edge on the synchronised signal with enable=1 copies COUNT into CAPTURE (reg 5) and sets STATUS bit1 (captured, write-1-clear, set wins).
  - A write to CAPTURE is ignored.
  - CAPTURE resets to 0.
- Undefined: capture_in is ignored, reg 5 and STATUS bit1 read 0, and no synchroniser logic is instantiated.

Test Plan:
1. Read/write: write PERIOD=0x0123, PRESCALE=0x0002 at base_addr+2 and +8 (wordsize 16) -> reads return 0x0123 and 0x0002 one cycle after addr. An unselected address returns 0x0000.
2. Auto-reload: PERIOD=3, PRESCALE=1, COUNT=3, CTRL=0x7 -> expired and irq rise after 8 cycles. They re-occur every 8 cycles after the first (irq stays high until cleared). Writing STATUS=1 drops irq the next cycle.
3. One-shot: COUNT=2, PRESCALE=0, CTRL=0x5 -> irq after 3 cycles. CTRL reads 0x4 and COUNT stays 0 for 20 further cycles.
4. Collisions: clear STATUS in the exact expiry cycle -> expired=1. Write COUNT=9 on a tick cycle -> COUNT reads 9.
5. Freeze/reset: drop enable mid-count -> COUNT and pcnt are unchanged for 10 cycles. Assert reset with COUNT=5 and run=1 -> all registers read 0 and irq=0.
6. (REFLET_TIMER_CAPTURE_EN) Pulse capture_in while COUNT=0x0040 -> CAPTURE reads 0x0040 ±2 (synchroniser latency) and STATUS bit1=1. Without the macro -> reg 5 reads 0.
